line_responder: RTL and testbench

LINE_RESPONDER -- requirements
Module: line_responder

---
 rtl/bus_pkg.sv | 14 +
 rtl/line_responder.sv | 135 +++++++++++++
 tb/tb_line_responder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: line responder FSM states and cache-line geometry helpers.
package bus_pkg;

  typedef enum logic [2:0] {IDLE, READ, RESP, WRITE, WACK, INVAL} state_t;

  function automatic int line_beats(input int offset_length);
    return 1 << offset_length;
  endfunction

  function automatic int line_bits(input int data_width, input int offset_length);
    return data_width * line_beats(offset_length);
  endfunction

endpackage

// File: rtl/line_responder.sv
// Converts whole-line cache fills/writebacks into word-sized memory requests,
// pulsing fill-valid, writeback-ready and a coherence invalidate on completion.
module line_responder
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             command_valid,
  input  logic                                             command_store,
  input  logic                                             command_rready,
  input  logic [ADDR_WIDTH-1:0]                            command_addr,
  input  logic [line_bits(DATA_WIDTH, OFFSET_LENGTH)-1:0]  data_to_bus,
  output logic [line_bits(DATA_WIDTH, OFFSET_LENGTH)-1:0]  data_from_bus,
  output logic                                             bus_valid,
  output logic                                             bus_ready,
  output logic                                             invalidate,
  output logic [ADDR_WIDTH-1:0]                            invalidate_addr,
  output logic                                             mem_req_valid,
  input  logic                                             mem_req_ready,
  output logic                                             mem_req_write,
  output logic [ADDR_WIDTH-1:0]                            mem_req_addr,
  output logic [DATA_WIDTH-1:0]                            mem_req_wdata,
  input  logic                                             mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                            mem_resp_rdata
);

  localparam int LINE_BITS = line_bits(DATA_WIDTH, OFFSET_LENGTH);
  localparam int BEATS     = line_beats(OFFSET_LENGTH);
  localparam int BASE_W    = ADDR_WIDTH - OFFSET_LENGTH;
  localparam int CNT_W     = OFFSET_LENGTH + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t                 state;
  logic [BASE_W-1:0]      base;
  logic [CNT_W-1:0]       issue_cnt;
  logic [CNT_W-1:0]       resp_cnt;
  logic [CNT_W-1:0]       issue_inc;
  logic [LINE_BITS-1:0]   line_buf;
  logic [LINE_BITS-1:0]   write_buf;
  logic                   req_fire;
  logic                   resp_take;
  logic                   unused_offset_bits;

  assign issue_inc          = issue_cnt + CNT_W'(1);
  assign req_fire           = mem_req_valid && mem_req_ready;
  // The MSB of resp_cnt flags a full line, so late responses fall through.
  assign resp_take          = (state == READ) && mem_resp_valid && !resp_cnt[OFFSET_LENGTH];
  assign data_from_bus      = line_buf;
  assign unused_offset_bits = ^command_addr[OFFSET_LENGTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      base            <= '0;
      issue_cnt       <= '0;
      resp_cnt        <= '0;
      line_buf        <= '0;
      write_buf       <= '0;
      bus_valid       <= 1'b0;
      bus_ready       <= 1'b0;
      invalidate      <= 1'b0;
      invalidate_addr <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_write   <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
    end else begin
      bus_valid  <= 1'b0;
      bus_ready  <= 1'b0;
      invalidate <= 1'b0;
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          resp_cnt  <= '0;
          if (command_valid && !command_store && command_rready) begin
            base          <= command_addr[ADDR_WIDTH-1:OFFSET_LENGTH];
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b0;
            mem_req_addr  <= {command_addr[ADDR_WIDTH-1:OFFSET_LENGTH], {OFFSET_LENGTH{1'b0}}};
            state         <= READ;
          end else if (command_valid && command_store) begin
            base          <= command_addr[ADDR_WIDTH-1:OFFSET_LENGTH];
            write_buf     <= data_to_bus;
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b1;
            mem_req_addr  <= {command_addr[ADDR_WIDTH-1:OFFSET_LENGTH], {OFFSET_LENGTH{1'b0}}};
            mem_req_wdata <= data_to_bus[DATA_WIDTH-1:0];
            state         <= WRITE;
          end
        end
        READ: begin
          if (req_fire) begin
            issue_cnt    <= issue_inc;
            mem_req_addr <= {base, issue_inc[OFFSET_LENGTH-1:0]};
            if (issue_cnt == LAST_BEAT) mem_req_valid <= 1'b0;
          end
          if (resp_take) begin
            line_buf[resp_cnt[OFFSET_LENGTH-1:0]*DATA_WIDTH +: DATA_WIDTH] <= mem_resp_rdata;
            resp_cnt <= resp_cnt + CNT_W'(1);
            if (resp_cnt == LAST_BEAT) begin
              bus_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        WRITE: begin
          if (req_fire) begin
            issue_cnt     <= issue_inc;
            mem_req_addr  <= {base, issue_inc[OFFSET_LENGTH-1:0]};
            mem_req_wdata <= write_buf[issue_inc[OFFSET_LENGTH-1:0]*DATA_WIDTH +: DATA_WIDTH];
            if (issue_cnt == LAST_BEAT) begin
              mem_req_valid <= 1'b0;
              mem_req_write <= 1'b0;
              bus_ready     <= 1'b1;
              state         <= WACK;
            end
          end
        end
        WACK: begin
          invalidate      <= 1'b1;
          invalidate_addr <= {base, {OFFSET_LENGTH{1'b0}}};
          state           <= INVAL;
        end
        INVAL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_responder.sv
// Randomised scoreboard bench for line_responder: stimulus queues expected memory
// requests and completion pulses; memory model and monitor pop and compare them.
module tb_line_responder;

  localparam int BEATS = 16;
  localparam int LB    = 1024;
  localparam logic [63:0] SALT = 64'h100;
  localparam int EV_FILL = 0;
  localparam int EV_WB   = 1;
  localparam int EV_INV  = 2;

  typedef struct { logic write; logic [63:0] addr; logic [63:0] wdata; } req_t;
  typedef struct { int kind; logic [63:0] addr; logic [LB-1:0] line; int cmd_edge; } evt_t;
  typedef struct { int due; logic [63:0] data; } resp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          command_valid = 1'b0, command_store = 1'b0, command_rready = 1'b0;
  logic [63:0]   command_addr = '0;
  logic [LB-1:0] data_to_bus = '0;
  logic [LB-1:0] data_from_bus;
  logic          bus_valid, bus_ready, invalidate;
  logic [63:0]   invalidate_addr;
  logic          mem_req_valid, mem_req_write;
  logic          mem_req_ready = 1'b0;
  logic [63:0]   mem_req_addr, mem_req_wdata;
  logic          mem_resp_valid = 1'b0;
  logic [63:0]   mem_resp_rdata = '0;

  int chk_cnt = 0, pass_cnt = 0;
  int cyc = 0, nidx = 0;
  int ready_mode = 0, resp_lat = 1, wr_accepted = 0;
  bit spurious = 1'b0;
  bit prev_bus_ready = 1'b0;
  req_t  exp_req[$];
  evt_t  exp_evt[$];
  resp_t pend[$];

  line_responder dut (
    .clk(clk), .reset(reset),
    .command_valid(command_valid), .command_store(command_store),
    .command_rready(command_rready), .command_addr(command_addr),
    .data_to_bus(data_to_bus), .data_from_bus(data_from_bus),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .invalidate(invalidate), .invalidate_addr(invalidate_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string msg);
    chk_cnt++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Memory model: in-order responses resp_lat cycles after acceptance; read word = addr + SALT.
  always @(negedge clk) begin
    req_t r;
    nidx++;
    if (!reset) begin
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      pend.delete();
    end else begin
      if (pend.size() != 0 && pend[0].due <= nidx) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pend[0].data;
        void'(pend.pop_front());
      end else if (spurious) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        spurious = 1'b0;
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = {$urandom, $urandom};
      end
      case (ready_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = nidx[0];
        default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_write) wr_accepted++;
        if (exp_req.size() == 0) begin
          fail_now("unexpected_req", $sformatf("got addr 0x%0h expected no request", mem_req_addr));
        end else begin
          r = exp_req.pop_front();
          chk("req_write", 64'(mem_req_write), 64'(r.write));
          chk("req_addr", mem_req_addr, r.addr);
          if (r.write) chk("req_wdata", mem_req_wdata, r.wdata);
        end
        if (!mem_req_write) pend.push_back('{nidx + resp_lat, mem_req_addr + SALT});
      end
    end
  end

  // Completion-pulse monitor.
  always @(negedge clk) begin
    evt_t e;
    int kind;
    if (!reset) begin
      prev_bus_ready = 1'b0;
    end else begin
      if (bus_valid || bus_ready || invalidate) begin
        chk("pulse_exclusive", 64'(int'(bus_valid) + int'(bus_ready) + int'(invalidate)), 64'(1));
        kind = bus_valid ? EV_FILL : (bus_ready ? EV_WB : EV_INV);
        if (exp_evt.size() == 0) begin
          fail_now("unexpected_pulse", $sformatf("got pulse kind %0d expected none", kind));
        end else begin
          e = exp_evt.pop_front();
          chk("pulse_kind", 64'(kind), 64'(e.kind));
          if (kind == EV_FILL && e.kind == EV_FILL) begin
            for (int i = 0; i < BEATS; i++)
              chk($sformatf("fill_word%0d", i), data_from_bus[i*64 +: 64], e.line[i*64 +: 64]);
            if (e.cmd_edge >= 0) chk("fill_latency", 64'(cyc + 1 - e.cmd_edge), 64'(BEATS + 2));
          end
          if (kind == EV_INV && e.kind == EV_INV) begin
            chk("inval_addr", invalidate_addr, e.addr);
            chk("inval_after_ready", 64'(prev_bus_ready), 64'(1));
          end
        end
      end
      prev_bus_ready = bus_ready;
    end
  end

  task automatic wait_done();
    int n = 0;
    while ((exp_req.size() != 0 || exp_evt.size() != 0) && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("txn_complete", 64'(n < 800), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic issue_fill(input logic [63:0] addr, input int hold, input bit timed);
    evt_t e;
    logic [63:0] wa;
    e.kind = EV_FILL; e.addr = '0; e.line = '0;
    e.cmd_edge = timed ? cyc + 1 : -1;
    for (int i = 0; i < BEATS; i++) begin
      wa = {addr[63:4], 4'(i)};
      exp_req.push_back('{1'b0, wa, 64'h0});
      e.line[i*64 +: 64] = wa + SALT;
    end
    exp_evt.push_back(e);
    $display("txn fill addr=0x%0h hold=%0d ready_mode=%0d lat=%0d", addr, hold, ready_mode, resp_lat);
    command_valid = 1'b1; command_store = 1'b0; command_rready = 1'b1; command_addr = addr;
    repeat (hold) begin @(posedge clk); #1; end
    command_valid = 1'b0; command_addr = {$urandom, $urandom};
    wait_done();
  endtask

  task automatic issue_wb(input logic [63:0] addr, input logic [LB-1:0] line, input bit wait_it);
    evt_t e;
    for (int i = 0; i < BEATS; i++)
      exp_req.push_back('{1'b1, {addr[63:4], 4'(i)}, line[i*64 +: 64]});
    e.kind = EV_WB; e.addr = '0; e.line = '0; e.cmd_edge = -1;
    exp_evt.push_back(e);
    e.kind = EV_INV; e.addr = {addr[63:4], 4'h0};
    exp_evt.push_back(e);
    $display("txn writeback addr=0x%0h ready_mode=%0d", addr, ready_mode);
    wr_accepted = 0;
    command_valid = 1'b1; command_store = 1'b1; command_rready = 1'($urandom_range(0, 1));
    command_addr = addr; data_to_bus = line;
    @(posedge clk); #1;
    command_valid = 1'b0; command_store = 1'b0; data_to_bus = '0;
    if (wait_it) wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_valid"}, 64'(bus_valid), 64'(0));
    chk({tag, "_bus_ready"}, 64'(bus_ready), 64'(0));
    chk({tag, "_invalidate"}, 64'(invalidate), 64'(0));
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'(0));
    chk({tag, "_req_write"}, 64'(mem_req_write), 64'(0));
    chk({tag, "_req_addr"}, mem_req_addr, 64'(0));
    chk({tag, "_req_wdata"}, mem_req_wdata, 64'(0));
    chk({tag, "_inval_addr"}, invalidate_addr, 64'(0));
    chk({tag, "_data_from_bus_nonzero"}, 64'(|data_from_bus), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LB-1:0] line;
    int n;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill request without rready must be ignored.
    command_valid = 1'b1; command_store = 1'b0; command_rready = 1'b0; command_addr = 64'h7770;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_fill_without_rready", 64'(mem_req_valid), 64'(0));
    end
    command_valid = 1'b0;
    @(posedge clk); #1;

    ready_mode = 0; resp_lat = 1;
    issue_fill(64'h1230, 1, 1'b1);

    for (int i = 0; i < BEATS; i++) line[i*64 +: 64] = 64'(i);
    issue_wb(64'h4000, line, 1'b1);

    ready_mode = 1; resp_lat = 3;
    issue_fill(64'hABCD_0000, 1, 1'b0);
    for (int i = 0; i < BEATS; i++) line[i*64 +: 64] = {$urandom, $urandom};
    issue_wb(64'h0000_0000_5555_AAA0, line, 1'b1);

    ready_mode = 0; resp_lat = 1;
    issue_fill(64'hFFFF_FFFF_FFFF_FFF7, 2, 1'b0);

    spurious = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_after_spurious", 64'(mem_req_valid), 64'(0));
    end
    issue_fill(64'h0000_0000_0000_2468, 1, 1'b0);

    // Reset in the middle of a writeback, with beat 7 on the request bus.
    for (int i = 0; i < BEATS; i++) line[i*64 +: 64] = {$urandom, $urandom};
    issue_wb(64'h9000, line, 1'b0);
    n = 0;
    while (wr_accepted < 7 && n < 200) begin @(negedge clk); n++; end
    chk("reached_beat7", 64'(wr_accepted), 64'(7));
    @(posedge clk); #2;
    reset = 1'b0;
    #1 check_all_zero("midreset");
    exp_req.delete();
    exp_evt.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    issue_fill(64'h0000_0000_0000_3100, 1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      ready_mode = $urandom_range(0, 2);
      resp_lat   = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        issue_fill({$urandom, $urandom}, $urandom_range(1, 2), 1'b0);
      end else begin
        for (int i = 0; i < BEATS; i++) line[i*64 +: 64] = {$urandom, $urandom};
        issue_wb({$urandom, $urandom}, line, 1'b1);
      end
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
